execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the hybrid ARM/MIPS pipeline, directly upstream of the memory stage. Computes ALU results, with single-cycle ops and an iterative 32-cycle multiplier, and maintains the NZCV flags. Its registered EX/MEM outputs drive the memory stage's address, store data, write enable and destination register. Asserts `stall` to freeze upstream stages during multiplies and inserts bubbles downstream.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; only 32 is supported.
- `MUL_CYCLES`, 32, number of multiplier iterations; equals `WIDTH`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  rising-edge clock.
  - `rst`  in  1  synchronous, active-high reset.
- Inputs:
  - `valid_in`  in  1  the instruction on the inputs is real.
  - `flush`  in  1  synchronous kill of the in-flight and presented instruction.
  - `ALUControl`  in  3  op select: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV (result = SrcB), 110 MUL, 111 reserved (result 0).
  - `SetFlags`  in  1  update NZCV.
  - `SrcA`, `SrcB`  in  32  operands.
  - `WriteDataIn`  in  32  store data, passed through.
  - `RdIn`  in  4  destination register.
  - `MEMWriteIn`, `RegWriteIn`, `MemToRegIn`  in  1 each  control, passed through.
- Outputs:
  - `stall`  out  1  combinational; upstream holds its inputs while high.
  - `valid_out`  out  1  registered; the EX/MEM slot holds a real instruction.
  - `ALUresult`  out  32  registered result; memory address for LDR/STR.
  - `WriteData`  out  32  registered store data.
  - `RdOut`  out  4  registered destination register.
  - `MEMWrite`, `RegWrite`, `MemToReg`  out  1 each  registered control.
  - `Flags`  out  4  registered NZCV, ordered {N,Z,C,V}.

## Operation
- FSM states: IDLE, MUL_BUSY.
- IDLE, non-MUL valid op:
  - Result is computed combinationally.
  - The EX/MEM register loads result, pass-through data and control at the next edge, with `valid_out`=1.
- IDLE, `valid_in` with MUL:
  - Capture SrcA (multiplicand), SrcB (multiplier), Rd and control.
  - Clear the accumulator, set count=0, go to MUL_BUSY.
  - The EX/MEM register loads a bubble.
- MUL_BUSY, each edge: if multiplier bit0 is set, add the shifted multiplicand to the accumulator; shift multiplicand left and multiplier right; count++.
- MUL_BUSY with count==31:
  - Final iteration.
  - EX/MEM loads the low 32 bits of the product and the captured control, with `valid_out`=1.
  - Go to IDLE.
- `stall` = (IDLE & valid_in & MUL & !flush) | (MUL_BUSY & count!=31 & !flush).
- Bubble: `valid_out`=0, `MEMWrite`=0, `RegWrite`=0, `MemToReg`=0; `ALUresult`, `WriteData` and `RdOut` are zeroed.
- `valid_in`=0 in IDLE: bubble loaded.
- Arithmetic and flags:
  - ADD: 33-bit sum; C = bit 32; V = (A[31]==B[31]) & (R[31]!=A[31]).
  - SUB: A + ~B + 1; C = carry out (1 means no borrow); V = (A[31]!=B[31]) & (R[31]!=A[31]).
  - AND/ORR/EOR/MOV/MUL: update N and Z only; C and V are held.
  - Reserved op: result 0; flags are not updated.
- Flags update at the edge the result enters EX/MEM, only if `SetFlags` is set and the instruction is valid and not flushed.
  - For MUL, `SetFlags` is captured at issue.
  - N = R[31]; Z = (R==0).
- Flush:
  - EX/MEM loads a bubble; FSM goes to IDLE; any MUL is abandoned; flags are unchanged.
  - An instruction presented in the same cycle is discarded.
  - `flush` has priority over everything except `rst`.
- Reset: all outputs and `Flags` are 0, FSM is in IDLE, count is 0; `stall`=0 during and after reset.

## Timing
- Single-cycle op: inputs present in cycle N; outputs valid after edge N+1.
- Back-to-back single-cycle ops: one per cycle, no stall.
- MUL presented at cycle N:
  - The capture edge ends cycle N; `stall` is high in cycles N..N+31 (32 cycles).
  - The product is registered at the edge ending cycle N+32.
  - `stall` is low in cycle N+32, so upstream advances at that same edge.
  - A following instruction presented in cycle N+32 is therefore accepted in N+33.
- EX/MEM holds bubbles for 32 cycles while a multiply is in progress.
- `stall` is a combinational function of state, `valid_in`, `ALUControl` and `flush`. It has no path from the EX/MEM outputs.
- Multiplier overflow: only the low 32 bits are kept; there is no high-word output.

## Test plan
- Reset, then ADD 0x7FFFFFFF+0x00000001 with SetFlags=1 → next cycle `ALUresult`=0x80000000, `Flags`=1001, `valid_out`=1.
- SUB 5−5 with SetFlags=1, then ORR 0xF0|0x0F with SetFlags=0 → `ALUresult` 0 then 0xFF. `Flags`=0110 after the SUB, held after the ORR.
- STR: ADD base 0x100 + 4 with MEMWriteIn=1, WriteDataIn=0xDEADBEEF, RdIn=3 → `ALUresult`=0x104, `WriteData`=0xDEADBEEF, `MEMWrite`=1, `RdOut`=3 for exactly one cycle.
- MUL 7×6 presented at cycle 0, then ADD 1+1 held on the inputs:
  - `stall` high in cycles 0–31; `valid_out`=0 and `MEMWrite`=0 during them.
  - 42 is registered at the end of cycle 32; the ADD result 2 follows one cycle later.
- MUL 0x00010000×0x00010000 with SetFlags=1 → `ALUresult`=0 and Z=1; C and V keep their prior values.
- Mid-operation aborts:
  - MUL issued, then `flush` pulsed in cycle 10 → no product ever appears, `stall` is low from cycle 10, and the next ADD completes normally.
  - Repeating the scenario with `rst` instead of `flush` → all outputs are 0.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative shift-add multiplier, NZCV flags,
// and the registered EX/MEM slot feeding the memory stage.
module execute_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [2:0]       ALUControl,
  input  logic             SetFlags,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] WriteDataIn,
  input  logic [3:0]       RdIn,
  input  logic             MEMWriteIn,
  input  logic             RegWriteIn,
  input  logic             MemToRegIn,
  output logic             stall,
  output logic             valid_out,
  output logic [WIDTH-1:0] ALUresult,
  output logic [WIDTH-1:0] WriteData,
  output logic [3:0]       RdOut,
  output logic             MEMWrite,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic [3:0]       Flags
);

  // state    | meaning
  // IDLE     | accepting one instruction per cycle
  // MUL_BUSY | multiplier iterating; upstream frozen until the final iteration
  typedef enum logic {IDLE, MUL_BUSY} state_t;

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_ORR = 3'b011, OP_EOR = 3'b100, OP_MOV = 3'b101,
                         OP_MUL = 3'b110;

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] cap_wd, cap_wd_nxt;
  logic [3:0]       cap_rd, cap_rd_nxt;
  logic             cap_mw, cap_mw_nxt;
  logic             cap_rw, cap_rw_nxt;
  logic             cap_mtr, cap_mtr_nxt;
  logic             cap_sf, cap_sf_nxt;

  logic             vo_nxt, mw_nxt, rw_nxt, mtr_nxt;
  logic [WIDTH-1:0] res_nxt, wd_nxt;
  logic [3:0]       rd_nxt, flags_nxt;

  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] alu_res, product;
  logic             alu_cv, alu_nz, alu_c, alu_v;
  logic             op_mul;

  assign op_mul  = (ALUControl == OP_MUL);
  assign sum_add = {1'b0, SrcA} + {1'b0, SrcB};
  assign sum_sub = {1'b0, SrcA} + {1'b0, ~SrcB} + (WIDTH+1)'(1);
  assign product = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_cv  = 1'b0;
    alu_nz  = 1'b1;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_cv  = 1'b1;
        alu_c   = sum_add[WIDTH];
        alu_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_cv  = 1'b1;
        alu_c   = sum_sub[WIDTH];
        alu_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND:  alu_res = SrcA & SrcB;
      OP_ORR:  alu_res = SrcA | SrcB;
      OP_EOR:  alu_res = SrcA ^ SrcB;
      OP_MOV:  alu_res = SrcB;
      default: alu_nz  = 1'b0;  // reserved op leaves flags alone
    endcase
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    acc_nxt     = acc;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    cap_wd_nxt  = cap_wd;
    cap_rd_nxt  = cap_rd;
    cap_mw_nxt  = cap_mw;
    cap_rw_nxt  = cap_rw;
    cap_mtr_nxt = cap_mtr;
    cap_sf_nxt  = cap_sf;
    vo_nxt      = 1'b0;
    res_nxt     = '0;
    wd_nxt      = '0;
    rd_nxt      = '0;
    mw_nxt      = 1'b0;
    rw_nxt      = 1'b0;
    mtr_nxt     = 1'b0;
    flags_nxt   = Flags;
    stall       = 1'b0;

    if (flush) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && op_mul) begin
            stall       = !rst;
            mcand_nxt   = SrcA;
            mplier_nxt  = SrcB;
            acc_nxt     = '0;
            count_nxt   = '0;
            cap_wd_nxt  = WriteDataIn;
            cap_rd_nxt  = RdIn;
            cap_mw_nxt  = MEMWriteIn;
            cap_rw_nxt  = RegWriteIn;
            cap_mtr_nxt = MemToRegIn;
            cap_sf_nxt  = SetFlags;
            state_nxt   = MUL_BUSY;
          end else if (valid_in) begin
            vo_nxt  = 1'b1;
            res_nxt = alu_res;
            wd_nxt  = WriteDataIn;
            rd_nxt  = RdIn;
            mw_nxt  = MEMWriteIn;
            rw_nxt  = RegWriteIn;
            mtr_nxt = MemToRegIn;
            if (SetFlags && alu_nz) begin
              flags_nxt[3:2] = {alu_res[WIDTH-1], alu_res == '0};
              if (alu_cv) flags_nxt[1:0] = {alu_c, alu_v};
            end
          end
        end
        MUL_BUSY: begin
          stall      = (count != LAST) && !rst;
          acc_nxt    = product;
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
          count_nxt  = count + CW'(1);
          if (count == LAST) begin
            vo_nxt    = 1'b1;
            res_nxt   = product;
            wd_nxt    = cap_wd;
            rd_nxt    = cap_rd;
            mw_nxt    = cap_mw;
            rw_nxt    = cap_rw;
            mtr_nxt   = cap_mtr;
            count_nxt = '0;
            state_nxt = IDLE;
            if (cap_sf) flags_nxt[3:2] = {product[WIDTH-1], product == '0};
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cap_wd    <= '0;
      cap_rd    <= '0;
      cap_mw    <= 1'b0;
      cap_rw    <= 1'b0;
      cap_mtr   <= 1'b0;
      cap_sf    <= 1'b0;
      valid_out <= 1'b0;
      ALUresult <= '0;
      WriteData <= '0;
      RdOut     <= '0;
      MEMWrite  <= 1'b0;
      RegWrite  <= 1'b0;
      MemToReg  <= 1'b0;
      Flags     <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      acc       <= acc_nxt;
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
      cap_wd    <= cap_wd_nxt;
      cap_rd    <= cap_rd_nxt;
      cap_mw    <= cap_mw_nxt;
      cap_rw    <= cap_rw_nxt;
      cap_mtr   <= cap_mtr_nxt;
      cap_sf    <= cap_sf_nxt;
      valid_out <= vo_nxt;
      ALUresult <= res_nxt;
      WriteData <= wd_nxt;
      RdOut     <= rd_nxt;
      MEMWrite  <= mw_nxt;
      RegWrite  <= rw_nxt;
      MemToReg  <= mtr_nxt;
      Flags     <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected EX/MEM contents are queued as each
// instruction is driven and checked one edge later; stall is checked every cycle.
module tb_execute_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [31:0] wd;
    logic [3:0]  rd;
    logic        mw;
    logic        rw;
    logic        mtr;
    logic [3:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, valid_in, flush, SetFlags;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA, SrcB, WriteDataIn;
  logic [3:0]  RdIn;
  logic        MEMWriteIn, RegWriteIn, MemToRegIn;
  logic        stall, valid_out, MEMWrite, RegWrite, MemToReg;
  logic [31:0] ALUresult, WriteData;
  logic [3:0]  RdOut, Flags;

  exp_t        q[$];
  logic [3:0]  mflags;
  int          total = 0;
  int          bad = 0;

  execute_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
    .ALUControl(ALUControl), .SetFlags(SetFlags), .SrcA(SrcA), .SrcB(SrcB),
    .WriteDataIn(WriteDataIn), .RdIn(RdIn), .MEMWriteIn(MEMWriteIn),
    .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .stall(stall),
    .valid_out(valid_out), .ALUresult(ALUresult), .WriteData(WriteData),
    .RdOut(RdOut), .MEMWrite(MEMWrite), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] op, input logic sf,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd,
                       input logic [3:0] rd, input logic mw, input logic rw, input logic mtr);
    valid_in = v; ALUControl = op; SetFlags = sf; SrcA = a; SrcB = b;
    WriteDataIn = wd; RdIn = rd; MEMWriteIn = mw; RegWriteIn = rw; MemToRegIn = mtr;
  endtask

  task automatic push_bubble();
    q.push_back('{v: 1'b0, res: 32'h0, wd: 32'h0, rd: 4'h0, mw: 1'b0, rw: 1'b0, mtr: 1'b0, fl: mflags});
  endtask

  // Reference arithmetic: plain 32-bit operators and compares, then flag policy.
  task automatic model_op(input logic [2:0] op, input logic sf, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r);
    logic [3:0] f;
    f = mflags;
    case (op)
      3'd0: begin
        r = a + b;
        f[1] = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
        f[0] = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        r = a - b;
        f[1] = (a >= b);
        f[0] = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = b;
      3'd6: r = a * b;
      default: r = 32'h0;
    endcase
    f[3] = r[31];
    f[2] = (r == 32'h0);
    if (sf && op != 3'd7) mflags = f;
  endtask

  task automatic tick(input string tag, input logic exp_stall);
    exp_t got, e;
    #1;
    total++;
    assert (stall === exp_stall) else begin
      bad++;
      $error("FAIL %s.stall got=%b exp=%b", tag, stall, exp_stall);
    end
    @(posedge clk);
    #1;
    got = '{v: valid_out, res: ALUresult, wd: WriteData, rd: RdOut, mw: MEMWrite,
            rw: RegWrite, mtr: MemToReg, fl: Flags};
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL %s.exmem no expected entry got=%h", tag, got);
    end else begin
      e = q.pop_front();
      assert (got === e) else begin
        bad++;
        $error("FAIL %s.exmem got=%h exp=%h", tag, got, e);
      end
    end
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic sf,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd,
                        input logic [3:0] rd, input logic mw, input logic rw, input logic mtr);
    logic [31:0] r;
    drive(1'b1, op, sf, a, b, wd, rd, mw, rw, mtr);
    model_op(op, sf, a, b, r);
    q.push_back('{v: 1'b1, res: r, wd: wd, rd: rd, mw: mw, rw: rw, mtr: mtr, fl: mflags});
    tick(tag, 1'b0);
  endtask

  task automatic idle_cycle(input string tag);
    drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    push_bubble();
    tick(tag, 1'b0);
  endtask

  // MUL issued in cycle 0 with ADD 1+1 waiting behind it; abort_at>0 pulses
  // flush (or rst) in that cycle instead of letting the product land.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sf, input logic [3:0] rd, input logic [31:0] wd,
                         input int abort_at, input logic use_rst);
    logic [31:0] r;
    drive(1'b1, 3'd6, sf, a, b, wd, rd, 1'b0, 1'b1, 1'b0);
    push_bubble();
    tick({tag, ".c0"}, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      drive(1'b1, 3'd0, 1'b1, 32'd1, 32'd1, 32'h0, 4'd9, 1'b0, 1'b1, 1'b0);
      if (c == abort_at) begin
        if (use_rst) begin
          rst = 1'b1;
          mflags = 4'h0;
        end else begin
          flush = 1'b1;
        end
        push_bubble();
        tick({tag, ".abort"}, 1'b0);
        rst = 1'b0;
        flush = 1'b0;
        return;
      end
      if (c < 32) begin
        push_bubble();
        tick({tag, ".busy"}, 1'b1);
      end else begin
        model_op(3'd6, sf, a, b, r);
        q.push_back('{v: 1'b1, res: r, wd: wd, rd: rd, mw: 1'b0, rw: 1'b1, mtr: 1'b0, fl: mflags});
        tick({tag, ".product"}, 1'b0);
      end
    end
    single({tag, ".follow_add"}, 3'd0, 1'b1, 32'd1, 32'd1, 32'h0, 4'd9, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    mflags = 4'h0;
    drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    push_bubble(); tick("reset0", 1'b0);
    push_bubble(); tick("reset1", 1'b0);
    rst = 1'b0;

    single("add_ovf", 3'd0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 4'd1, 1'b0, 1'b1, 1'b0);
    single("sub_zero", 3'd1, 1'b1, 32'd5, 32'd5, 32'h0, 4'd2, 1'b0, 1'b1, 1'b0);
    single("orr_noflags", 3'd3, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0, 4'd2, 1'b0, 1'b1, 1'b0);
    single("str_addr", 3'd0, 1'b0, 32'h0000_0100, 32'd4, 32'hDEAD_BEEF, 4'd3, 1'b1, 1'b0, 1'b0);
    idle_cycle("str_gone");
    single("ldr_addr", 3'd0, 1'b0, 32'h0000_0200, 32'd8, 32'h0, 4'd4, 1'b0, 1'b1, 1'b1);
    single("sub_borrow", 3'd1, 1'b1, 32'd3, 32'd5, 32'h0, 4'd5, 1'b0, 1'b1, 1'b0);
    single("sub_sovf", 3'd1, 1'b1, 32'h8000_0000, 32'd1, 32'h0, 4'd5, 1'b0, 1'b1, 1'b0);
    single("and", 3'd2, 1'b1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 4'd6, 1'b0, 1'b1, 1'b0);
    single("eor", 3'd4, 1'b1, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 4'd7, 1'b0, 1'b1, 1'b0);
    single("mov", 3'd5, 1'b1, 32'h1234_5678, 32'h8000_0001, 32'h0, 4'd8, 1'b0, 1'b1, 1'b0);
    single("reserved", 3'd7, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 4'd8, 1'b0, 1'b1, 1'b0);
    idle_cycle("idle");

    run_mul("mul7x6", 32'd7, 32'd6, 1'b0, 4'd5, 32'h0, 0, 1'b0);
    single("set_cv", 3'd0, 1'b1, 32'h8000_0000, 32'h8000_0001, 32'h0, 4'd1, 1'b0, 1'b1, 1'b0);
    run_mul("mul_wrap", 32'h0001_0000, 32'h0001_0000, 1'b1, 4'd6, 32'h0, 0, 1'b0);
    run_mul("mul_rand", $urandom, $urandom, 1'b1, 4'd10, 32'h5A5A_0001, 0, 1'b0);

    run_mul("mul_flush", 32'd9, 32'd9, 1'b1, 4'd11, 32'h0, 10, 1'b0);
    single("after_flush", 3'd0, 1'b0, 32'd20, 32'd22, 32'h0, 4'd12, 1'b0, 1'b1, 1'b0);
    idle_cycle("flush_quiet0");
    idle_cycle("flush_quiet1");

    run_mul("mul_rst", 32'd9, 32'd9, 1'b1, 4'd11, 32'h0, 10, 1'b1);
    idle_cycle("rst_quiet0");
    idle_cycle("rst_quiet1");
    single("after_rst", 3'd0, 1'b1, 32'd2, 32'd3, 32'h0, 4'd13, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
